// File: rtl/color_pkg.sv
// +--------------------------------------------------------------------+
// | color_pkg: state enums and code constants shared by Color FSM/decoder |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package color_pkg;

  typedef enum logic {
    BLUE = 1'h0,
    RED  = 1'h1
  } Color_state;

  localparam logic [1:0] CODE_NONE    = 2'h0;
  localparam logic [1:0] CODE_TO_BLUE = 2'h1;
  localparam logic [1:0] CODE_RED     = 2'h2;
  localparam logic [1:0] CODE_ILLEGAL = 2'h3;

  typedef enum logic [1:0] {
    DEC_RED  = 2'd0,
    DEC_BLUE = 2'd1,
    DEC_ERR  = 2'd2
  } dec_state_e;

endpackage

`default_nettype wire

// File: rtl/color_decoder_if.sv
// +--------------------------------------------------------------------+
// | color_decoder_if: code input stream and recovered-input output port  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

interface color_decoder_if;
  logic [1:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [1:0] rec_in;
  logic       rec_valid;
  logic       rec_ready;

  modport master (
    output code, code_valid, rec_ready,
    input  code_ready, rec_in, rec_valid
  );

  modport slave (
    input  code, code_valid, rec_ready,
    output code_ready, rec_in, rec_valid
  );
endinterface

`default_nettype wire

// File: rtl/color_decoder_sat_counter.sv
// +--------------------------------------------------------------------+
// | sat_counter: up-counter that holds at all-ones instead of wrapping   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  output logic [WIDTH-1:0]      count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/color_decoder.sv
// +--------------------------------------------------------------------+
// | color_decoder: tracks the Color FSM from its output codes, recovers  |
// | inputs, flags illegal codes. Rev 1.0                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module color_decoder
  import color_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 clear,
  color_decoder_if.slave            bus,
  output logic                      cur_state,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [CNT_WIDTH-1:0]      toggle_count
);

  dec_state_e state_q, state_d;
  Color_state cur_state_q, cur_state_d;
  logic       error_q, error_d;
  logic [1:0] err_code_q, err_code_d;
  logic [1:0] rec_in_q, rec_in_d;
  logic       rec_valid_q, rec_valid_d;

  logic       code_ready;
  logic       accept;
  logic       pop;
  logic       push;
  logic [1:0] push_val;
  logic       toggle;

  assign code_ready = (!rec_valid_q || bus.rec_ready) && (state_q != DEC_ERR) && !clear;
  assign accept     = bus.code_valid && code_ready;
  assign pop        = rec_valid_q && bus.rec_ready;

  always_comb begin
    state_d     = state_q;
    cur_state_d = cur_state_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    push        = 1'b0;
    push_val    = 2'd0;
    toggle      = 1'b0;

    if (clear) begin
      state_d     = DEC_RED;
      cur_state_d = RED;
      error_d     = 1'b0;
      err_code_d  = CODE_NONE;
    end else if (accept) begin
      case (state_q)
        DEC_RED: begin
          case (bus.code)
            CODE_TO_BLUE: begin
              state_d     = DEC_BLUE;
              cur_state_d = BLUE;
              push        = 1'b1;
              push_val    = 2'd1;
              toggle      = 1'b1;
            end
            CODE_RED: begin
              push     = 1'b1;
              push_val = 2'd0;
            end
            CODE_ILLEGAL: begin
              state_d    = DEC_ERR;
              error_d    = 1'b1;
              err_code_d = bus.code;
            end
            default: ;
          endcase
        end
        DEC_BLUE: begin
          case (bus.code)
            CODE_RED: begin
              state_d     = DEC_RED;
              cur_state_d = RED;
              push        = 1'b1;
              push_val    = 2'd1;
              toggle      = 1'b1;
            end
            CODE_NONE: ;
            default: begin
              state_d    = DEC_ERR;
              error_d    = 1'b1;
              err_code_d = bus.code;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // A push wins over a same-cycle pop so the register reloads without a bubble.
  always_comb begin
    rec_valid_d = rec_valid_q;
    rec_in_d    = rec_in_q;
    if (push) begin
      rec_valid_d = 1'b1;
      rec_in_d    = push_val;
    end else if (pop) begin
      rec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DEC_RED;
      cur_state_q <= RED;
      error_q     <= 1'b0;
      err_code_q  <= CODE_NONE;
      rec_in_q    <= 2'd0;
      rec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_state_q <= cur_state_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      rec_in_q    <= rec_in_d;
      rec_valid_q <= rec_valid_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_toggle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (toggle),
    .count (toggle_count)
  );

  assign bus.code_ready = code_ready;
  assign bus.rec_in     = rec_in_q;
  assign bus.rec_valid  = rec_valid_q;
  assign cur_state      = cur_state_q;
  assign error          = error_q;
  assign err_code       = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_color_decoder.sv
// +--------------------------------------------------------------------+
// | tb_color_decoder: directed + random stimulus against a table model   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_color_decoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             cur_state;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] toggle_count;

  color_decoder_if bus_if ();

  color_decoder #(
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .bus          (bus_if.slave),
    .cur_state    (cur_state),
    .error        (error),
    .err_code     (err_code),
    .toggle_count (toggle_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: FSM colour, error flag, saturating count, one-deep output queue.
  bit         m_red;
  bit         m_err;
  logic [1:0] m_err_code;
  int         m_cnt;
  logic [1:0] m_rec_in;
  logic [1:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_red      = 1'b1;
    m_err      = 1'b0;
    m_err_code = 2'd0;
    m_cnt      = 0;
    m_rec_in   = 2'd0;
    m_q.delete();
  endtask

  task automatic model_push(input logic [1:0] v);
    m_q.push_back(v);
    m_rec_in = v;
  endtask

  // One clock: drive inputs, check code_ready, advance model, check registered outputs.
  task automatic step(input bit r, input bit cl, input bit cv, input logic [1:0] c, input bit rr);
    bit exp_ready;
    bit acc;
    rst               = r;
    clear             = cl;
    bus_if.code_valid = cv;
    bus_if.code       = c;
    bus_if.rec_ready  = rr;
    #1;
    exp_ready = ((m_q.size() == 0) || rr) && !m_err && !cl;
    chk("code_ready", {31'd0, bus_if.code_ready}, {31'd0, exp_ready});
    acc = cv && exp_ready;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if ((m_q.size() != 0) && rr) void'(m_q.pop_front());
      if (cl) begin
        m_err      = 1'b0;
        m_red      = 1'b1;
        m_err_code = 2'd0;
      end else if (acc) begin
        if (m_red) begin
          if (c == 2'd1) begin m_red = 1'b0; model_push(2'd1); m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt; end
          else if (c == 2'd2) model_push(2'd0);
          else if (c == 2'd3) begin m_err = 1'b1; m_err_code = c; end
        end else begin
          if (c == 2'd2) begin m_red = 1'b1; model_push(2'd1); m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt; end
          else if (c != 2'd0) begin m_err = 1'b1; m_err_code = c; end
        end
      end
    end
    chk("rec_valid",    {31'd0, bus_if.rec_valid}, {31'd0, m_q.size() != 0});
    chk("rec_in",       {30'd0, bus_if.rec_in},    {30'd0, m_rec_in});
    chk("cur_state",    {31'd0, cur_state},        {31'd0, m_red});
    chk("error",        {31'd0, error},            {31'd0, m_err});
    chk("err_code",     {30'd0, err_code},         {30'd0, m_err_code});
    chk("toggle_count", {30'd0, toggle_count},     m_cnt);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus_if.code_valid = 1'b0; bus_if.code = 2'd0; bus_if.rec_ready = 1'b1;
    model_reset();
    step(1, 0, 0, 2'd0, 1);
    step(1, 0, 0, 2'd0, 1);

    // Codes 1,2,2 back to back: rec_in 1,1,0 and two toggles.
    step(0, 0, 1, 2'd1, 1);
    step(0, 0, 1, 2'd2, 1);
    step(0, 0, 1, 2'd2, 1);
    step(0, 0, 0, 2'd0, 1);
    // Code 0 in Red pushes nothing.
    step(0, 0, 1, 2'd0, 1);
    step(0, 0, 0, 2'd0, 1);

    // Blue then code 1 -> error; clear with a held code; code consumed next cycle.
    step(0, 0, 1, 2'd1, 1);
    step(0, 0, 1, 2'd1, 1);
    step(0, 0, 1, 2'd1, 1);
    step(0, 1, 1, 2'd1, 1);
    step(0, 0, 1, 2'd1, 1);

    // Stall: output held, no code accepted, then release with a code in the pop cycle.
    step(0, 0, 1, 2'd2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'd0, 0);
    step(0, 0, 1, 2'd2, 1);
    step(0, 0, 0, 2'd0, 1);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 2'd1, 1);
      step(0, 0, 1, 2'd2, 1);
    end

    // Reset with a pending output while in Blue.
    step(0, 0, 1, 2'd1, 0);
    step(1, 0, 0, 2'd0, 0);
    step(0, 0, 0, 2'd0, 1);

    // Illegal code from Red.
    step(0, 0, 1, 2'd3, 1);
    step(0, 1, 0, 2'd0, 1);

    for (int i = 0; i < 400; i++) begin
      bit r, cl, cv, rr;
      logic [1:0] c;
      r  = ($urandom_range(0, 99) == 0);
      cl = m_err && ($urandom_range(0, 2) == 0);
      cv = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rr = ($urandom_range(0, 3) != 0);
      step(r, cl, cv, c, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
